// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_stage_pkg;

  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    KILL = 2'd1,
    HELD = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0060;
  localparam instr_t      IF_NOP_INSTR = 32'h0000_0013;

  // One fetched word together with the address it came from.
  typedef struct packed {
    instr_t      instr;
    logic [31:0] pc;
  } fetch_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// I-side memory port: the fetch stage is the master, the instruction memory the slave.
interface if_stage_if;
  import if_stage_pkg::*;

  logic        imem_read;
  logic [31:0] imem_address;
  instr_t      imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );

endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats load, and with neither asserted the contents hold.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter instr_t NOP_INSTR = IF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  fetch_t      i_fetch,
  output instr_t      o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  instr_t      r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_fetch.instr;
      r_pc    <= i_fetch.pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM and a one-entry skid buffer feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter instr_t      NOP_INSTR = IF_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  if_stage_if.master        imem,
  input  logic              i_stall_id,
  input  logic              i_ex_br_en,
  input  logic [31:0]       i_ex_br_target,
  output instr_t            o_ifid_instruction,
  output logic [31:0]       o_ifid_pc,
  output logic              o_ifid_valid
);

  if_state_e   r_state, w_next_state;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_target, w_target_next;
  fetch_t      r_buf, w_ifid_data;
  logic        w_buf_load, w_ifid_load, w_ifid_flush;
  logic [31:0] w_br_target, w_pc_plus4;

  assign w_br_target = word_align(i_ex_br_target);
  assign w_pc_plus4  = r_pc + 32'd4;

  // The request stays up until its response; HELD is the only state with nothing outstanding.
  assign imem.imem_read    = (r_state != HELD);
  assign imem.imem_address = r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= REQ;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
      r_buf    <= '0;
    end else begin
      r_state  <= w_next_state;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
      if (w_buf_load) r_buf <= '{instr: imem.imem_rdata, pc: r_pc};
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    w_buf_load    = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_ifid_data   = '{instr: imem.imem_rdata, pc: r_pc};

    case (r_state)
      REQ: begin
        if (i_ex_br_en) begin
          w_ifid_flush = 1'b1;
          if (imem.imem_resp) begin
            w_pc_next = w_br_target;
          end else begin
            w_target_next = w_br_target;
            w_next_state  = KILL;
          end
        end else if (imem.imem_resp) begin
          w_pc_next = w_pc_plus4;
          if (i_stall_id) begin
            w_buf_load   = 1'b1;
            w_next_state = HELD;
          end else begin
            w_ifid_load = 1'b1;
          end
        end else if (!i_stall_id) begin
          w_ifid_flush = 1'b1;
        end
      end

      // Waiting out a stale fetch; a later redirect simply replaces the pending target.
      KILL: begin
        w_ifid_flush = i_ex_br_en | ~i_stall_id;
        if (i_ex_br_en) w_target_next = w_br_target;
        if (imem.imem_resp) begin
          w_pc_next    = i_ex_br_en ? w_br_target : r_target;
          w_next_state = REQ;
        end
      end

      HELD: begin
        w_ifid_data = r_buf;
        if (i_ex_br_en) begin
          w_ifid_flush = 1'b1;
          w_pc_next    = w_br_target;
          w_next_state = REQ;
        end else if (!i_stall_id) begin
          w_ifid_load  = 1'b1;
          w_next_state = REQ;
        end
      end

      default: w_next_state = REQ;
    endcase
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_fetch (w_ifid_data),
    .o_instr (o_ifid_instruction),
    .o_pc    (o_ifid_pc),
    .o_valid (o_ifid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: scripted memory grants plus a scoreboard of expected IF/ID words.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_id;
  logic        ex_br_en;
  logic [31:0] ex_br_target;
  instr_t      ifid_instruction;
  logic [31:0] ifid_pc;
  logic        ifid_valid;

  if_stage_if mif ();

  if_stage u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem               (mif),
    .i_stall_id         (stall_id),
    .i_ex_br_en         (ex_br_en),
    .i_ex_br_target     (ex_br_target),
    .o_ifid_instruction (ifid_instruction),
    .o_ifid_pc          (ifid_pc),
    .o_ifid_valid       (ifid_valid)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  int     mem_grants;
  int     mem_used = 0;
  fetch_t exp_q[$];

  function automatic instr_t mem_word(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0003;
  endfunction

  // Memory answers in the same cycle it sees a request, but only for granted responses.
  always @(negedge clk) begin
    mif.imem_resp = 1'b0;
    if (rst_n === 1'b1 && mif.imem_read === 1'b1 && mem_used < mem_grants) begin
      mif.imem_resp  = 1'b1;
      mif.imem_rdata = mem_word(mif.imem_address);
      mem_used++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back('{instr: mem_word(pc), pc: pc});
  endtask

  initial begin
    rst_n        = 1'b0;
    stall_id     = 1'b0;
    ex_br_en     = 1'b0;
    ex_br_target = '0;
    mem_grants   = 0;
    mif.imem_resp  = 1'b0;
    mif.imem_rdata = '0;

    // Scoreboard monitor: each newly presented IF/ID word is matched against the queue.
    fork
      begin
        logic        prev_v  = 1'b0;
        logic [31:0] prev_pc = '0;
        fetch_t      e;
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && ifid_valid === 1'b1 && (!prev_v || ifid_pc !== prev_pc)) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL sb_unexpected: got pc=%h instr=%h expected none", ifid_pc, ifid_instruction);
            end else begin
              e = exp_q.pop_front();
              check("sb_pc", ifid_pc, e.pc);
              check("sb_instr", ifid_instruction, e.instr);
            end
          end
          prev_v  = ifid_valid;
          prev_pc = ifid_pc;
        end
      end
    join_none

    // Reset state
    repeat (2) step();
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instruction, 32'h0000_0013);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_addr", mif.imem_address, 32'h60);
    rst_n = 1'b1;
    step();
    check("t1_read", {31'd0, mif.imem_read}, 32'd1);
    check("t1_addr0", mif.imem_address, 32'h60);

    // 1: three back-to-back fetches, one-cycle visibility
    expect_fetch(32'h60); expect_fetch(32'h64); expect_fetch(32'h68);
    mem_grants += 3;
    step();
    check("t1_resp", {31'd0, mif.imem_resp}, 32'd1);
    step();
    check("t1_lat_pc", ifid_pc, 32'h60);
    check("t1_addr1", mif.imem_address, 32'h64);
    step();
    step();
    check("t1_last_pc", ifid_pc, 32'h68);
    check("t1_addr3", mif.imem_address, 32'h6C);
    step();
    check("t1_bubble", {31'd0, ifid_valid}, 32'd0);

    // 2: response under stall goes to the buffer, IF/ID holds
    expect_fetch(32'h6C); expect_fetch(32'h70);
    mem_grants += 1;
    step();
    step();
    stall_id = 1'b1;
    mem_grants += 1;
    step();
    check("t2_hold_pc", ifid_pc, 32'h6C);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_held_read", {31'd0, mif.imem_read}, 32'd0);
      check("t2_held_pc", ifid_pc, 32'h6C);
      check("t2_held_instr", ifid_instruction, mem_word(32'h6C));
      check("t2_held_addr", mif.imem_address, 32'h74);
    end
    stall_id = 1'b0;
    step();
    check("t2_rel_pc", ifid_pc, 32'h70);
    check("t2_rel_read", {31'd0, mif.imem_read}, 32'd1);

    // 3: redirect with a fetch outstanding
    ex_br_en = 1'b1; ex_br_target = 32'h200;
    step();
    ex_br_en = 1'b0;
    check("t3_kill_addr", mif.imem_address, 32'h74);
    check("t3_kill_valid", {31'd0, ifid_valid}, 32'd0);
    step();
    check("t3_kill_read", {31'd0, mif.imem_read}, 32'd1);
    mem_grants += 1;
    step();
    step();
    check("t3_target", mif.imem_address, 32'h200);
    check("t3_valid", {31'd0, ifid_valid}, 32'd0);
    expect_fetch(32'h200);
    mem_grants += 1;
    step();
    step();
    check("t3_new_pc", ifid_pc, 32'h200);

    // 4: redirect and response in the same cycle, misaligned target
    mem_grants += 1;
    step();
    ex_br_en = 1'b1; ex_br_target = 32'h1003;
    step();
    ex_br_en = 1'b0;
    check("t4_addr", mif.imem_address, 32'h1000);
    check("t4_valid", {31'd0, ifid_valid}, 32'd0);

    // 5: redirect while HELD and stalled drops the buffer
    expect_fetch(32'h1000);
    mem_grants += 1;
    step();
    step();
    stall_id = 1'b1;
    mem_grants += 1;
    step();
    step();
    check("t5_held_read", {31'd0, mif.imem_read}, 32'd0);
    check("t5_held_valid", {31'd0, ifid_valid}, 32'd1);
    ex_br_en = 1'b1; ex_br_target = 32'h2000;
    step();
    ex_br_en = 1'b0;
    stall_id = 1'b0;
    check("t5_flush_valid", {31'd0, ifid_valid}, 32'd0);
    check("t5_addr", mif.imem_address, 32'h2000);
    check("t5_read", {31'd0, mif.imem_read}, 32'd1);
    expect_fetch(32'h2000);
    mem_grants += 1;
    step();
    step();

    // 6: PC wrap, then async reset in KILL
    ex_br_en = 1'b1; ex_br_target = 32'hFFFF_FFFC;
    step();
    ex_br_en = 1'b0;
    mem_grants += 1;
    step();
    step();
    check("t6_top_addr", mif.imem_address, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    mem_grants += 1;
    step();
    step();
    check("t6_wrap_addr", mif.imem_address, 32'h0);
    check("t6_wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    ex_br_en = 1'b1; ex_br_target = 32'h500;
    step();
    ex_br_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("t6_rst_instr", ifid_instruction, 32'h0000_0013);
    check("t6_rst_pc", ifid_pc, 32'd0);
    check("t6_rst_addr", mif.imem_address, 32'h60);
    check("t6_rst_read", {31'd0, mif.imem_read}, 32'd1);
    step();
    rst_n = 1'b1;
    step();
    expect_fetch(32'h60);
    mem_grants += 1;
    step();
    step();
    check("t6_refetch_pc", ifid_pc, 32'h60);
    check("t6_next_addr", mif.imem_address, 32'h64);

    repeat (3) step();
    check("sb_drain", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
